// File: rtl/tri_frame_sequencer.sv
// tri_frame_sequencer: packs six serial W-bit coordinate words into one
// parallel a..f frame for the triangle-compare core. It waits CORE_LAT
// cycles, captures the core's out/max result, and returns it over a
// valid/ready result port.
// Optional feature macro: TRI_FRAME_PEAK_EN adds peak_out/peak_idx tracking
// of the largest result seen so far. Ties keep the earlier frame.
module tri_frame_sequencer #(
    parameter int unsigned W        = 9,
    parameter int unsigned OW       = 17,
    parameter int unsigned CORE_LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic [W-1:0]  a,
    output logic [W-1:0]  b,
    output logic [W-1:0]  c,
    output logic [W-1:0]  d,
    output logic [W-1:0]  e,
    output logic [W-1:0]  f,
    input  logic [OW-1:0] core_out,
    input  logic [W-1:0]  core_max,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [OW-1:0] res_out,
    output logic [W-1:0]  res_max,
    output logic [10:0]   frame_cnt,
    output logic          busy
`ifdef TRI_FRAME_PEAK_EN
    ,
    output logic [OW-1:0] peak_out,
    output logic [10:0]   peak_idx
`endif
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(CORE_LAT);

    state_t       state;
    logic [2:0]   idx;
    logic [3:0]   wait_cnt;
    logic [W-1:0] shadow [0:4];

    // Frame collection, core-latency wait, and result hand-off. Every output is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_COLLECT;
            idx       <= '0;
            wait_cnt  <= '0;
            for (int unsigned i = 0; i < 5; i++) shadow[i] <= '0;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            d         <= '0;
            e         <= '0;
            f         <= '0;
            res_out   <= '0;
            res_max   <= '0;
            res_valid <= 1'b0;
            frame_cnt <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
`ifdef TRI_FRAME_PEAK_EN
            peak_out  <= '0;
            peak_idx  <= '0;
`endif
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (in_valid && in_ready) begin
                        if (idx == 3'd5) begin
                            // The sixth word bypasses the shadow so all six slots update on the same edge.
                            a        <= shadow[0];
                            b        <= shadow[1];
                            c        <= shadow[2];
                            d        <= shadow[3];
                            e        <= shadow[4];
                            f        <= in_data;
                            idx      <= '0;
                            wait_cnt <= LAT;
                            state    <= ST_WAIT;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            shadow[idx] <= in_data;
                            idx         <= idx + 3'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        res_out   <= core_out;
                        res_max   <= core_max;
                        res_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        frame_cnt <= frame_cnt + 11'd1;
                        state     <= ST_COLLECT;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
`ifdef TRI_FRAME_PEAK_EN
                        if (res_out > peak_out) begin
                            peak_out <= res_out;
                            peak_idx <= frame_cnt;
                        end
`endif
                    end
                end
                default: begin
                    state    <= ST_COLLECT;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_frame_sequencer.sv
// Directed testbench for tri_frame_sequencer. It uses two instances:
// dut0 runs with CORE_LAT=0 and dut3 runs with CORE_LAT=3.
// The core is modelled as out = sum(a..f) and max = max(a..f).
module tb_tri_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  in_data = '0;
    logic [8:0]  a, b, c, d, e, f;
    logic [16:0] core_out;
    logic [8:0]  core_max;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [16:0] res_out;
    logic [8:0]  res_max;
    logic [10:0] frame_cnt;
    logic        busy;

    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [8:0]  in_data3 = '0;
    logic [8:0]  a3, b3, c3, d3, e3, f3;
    logic [16:0] core_out3;
    logic [8:0]  core_max3;
    logic        res_valid3;
    logic        res_ready3 = 1'b0;
    logic [16:0] res_out3;
    logic [8:0]  res_max3;
    logic [10:0] frame_cnt3;
    logic        busy3;

`ifdef TRI_FRAME_PEAK_EN
    logic [16:0] peak_out, peak_out3;
    logic [10:0] peak_idx, peak_idx3;
`endif

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    function automatic logic [8:0] max6(input logic [8:0] p0, p1, p2, p3, p4, p5);
        logic [8:0] m;
        m = p0;
        if (p1 > m) m = p1;
        if (p2 > m) m = p2;
        if (p3 > m) m = p3;
        if (p4 > m) m = p4;
        if (p5 > m) m = p5;
        return m;
    endfunction

    // Core model: the sum is zero-extended, so the result is never truncated.
    assign core_out  = 17'(a) + 17'(b) + 17'(c) + 17'(d) + 17'(e) + 17'(f);
    assign core_max  = max6(a, b, c, d, e, f);
    assign core_out3 = 17'(a3) + 17'(b3) + 17'(c3) + 17'(d3) + 17'(e3) + 17'(f3);
    assign core_max3 = max6(a3, b3, c3, d3, e3, f3);

    tri_frame_sequencer #(.W(9), .OW(17), .CORE_LAT(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .core_out(core_out), .core_max(core_max),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_out(res_out), .res_max(res_max),
        .frame_cnt(frame_cnt), .busy(busy)
`ifdef TRI_FRAME_PEAK_EN
        , .peak_out(peak_out), .peak_idx(peak_idx)
`endif
    );

    tri_frame_sequencer #(.W(9), .OW(17), .CORE_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .a(a3), .b(b3), .c(c3), .d(d3), .e(e3), .f(f3),
        .core_out(core_out3), .core_max(core_max3),
        .res_valid(res_valid3), .res_ready(res_ready3),
        .res_out(res_out3), .res_max(res_max3),
        .frame_cnt(frame_cnt3), .busy(busy3)
`ifdef TRI_FRAME_PEAK_EN
        , .peak_out(peak_out3), .peak_idx(peak_idx3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " a"}, 32'(a), 0);
        chk({tag, " b"}, 32'(b), 0);
        chk({tag, " c"}, 32'(c), 0);
        chk({tag, " d"}, 32'(d), 0);
        chk({tag, " e"}, 32'(e), 0);
        chk({tag, " f"}, 32'(f), 0);
        chk({tag, " res_out"}, 32'(res_out), 0);
        chk({tag, " res_max"}, 32'(res_max), 0);
        chk({tag, " res_valid"}, 32'(res_valid), 0);
        chk({tag, " frame_cnt"}, 32'(frame_cnt), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " in_ready"}, 32'(in_ready), 1);
    endtask

    // Drives one word and returns #1 after the edge that accepted it.
    // in_valid is left high so that back-to-back calls stream words without gaps.
    task automatic send_word(input logic [8:0] w);
        int unsigned n;
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            $error("FAIL send_word_timeout: in_ready got 0 expected 1");
        end
        tick();
    endtask

    task automatic wait_valid(input string tag);
        int unsigned n;
        n = 0;
        while (!res_valid && n < 50) begin
            tick();
            n++;
        end
        if (!res_valid) begin
            total++;
            $error("FAIL %s: res_valid timeout got 0 expected 1", tag);
        end
    endtask

    // Sends one full frame and completes its result handshake; expects res_ready=1.
    task automatic run_frame(input logic [8:0] w0, w1, w2, w3, w4, w5);
        send_word(w0); send_word(w1); send_word(w2);
        send_word(w3); send_word(w4); send_word(w5);
        in_valid = 1'b0;
        wait_valid("run_frame");
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_zero("reset");
        chk("reset busy3", 32'(busy3), 0);
        chk("reset in_ready3", 32'(in_ready3), 1);
        rst = 1'b0;

        // Basic frame 1..6, streamed with in_valid held high
        res_ready = 1'b1;
        for (int i = 1; i <= 5; i++) send_word(9'(i));
        chk("partial a stable", 32'(a), 0);
        chk("partial e stable", 32'(e), 0);
        send_word(9'd6);
        chk("frame1 a", 32'(a), 1);
        chk("frame1 b", 32'(b), 2);
        chk("frame1 c", 32'(c), 3);
        chk("frame1 d", 32'(d), 4);
        chk("frame1 e", 32'(e), 5);
        chk("frame1 f", 32'(f), 6);
        chk("frame1 busy", 32'(busy), 1);
        chk("frame1 in_ready", 32'(in_ready), 0);
        chk("frame1 res_valid early", 32'(res_valid), 0);
        in_valid = 1'b0;
        tick();
        chk("frame1 res_valid", 32'(res_valid), 1);
        chk("frame1 res_out", 32'(res_out), 21);
        chk("frame1 res_max", 32'(res_max), 6);
        tick();
        chk("frame1 handshake res_valid", 32'(res_valid), 0);
        chk("frame1 frame_cnt", 32'(frame_cnt), 1);
        chk("frame1 in_ready after", 32'(in_ready), 1);
        chk("frame1 busy after", 32'(busy), 0);

        // All-ones words with a stalled consumer
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_word(9'h1FF);
        in_valid = 1'b0;
        tick();
        chk("max res_valid", 32'(res_valid), 1);
        chk("max res_out", 32'(res_out), 3066);
        chk("max res_max", 32'(res_max), 511);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("stall res_valid", 32'(res_valid), 1);
            chk("stall res_out", 32'(res_out), 3066);
            chk("stall res_max", 32'(res_max), 511);
            chk("stall a", 32'(a), 511);
            chk("stall f", 32'(f), 511);
            chk("stall in_ready", 32'(in_ready), 0);
            chk("stall busy", 32'(busy), 1);
        end
        res_ready = 1'b1;
        tick();
        chk("stall release frame_cnt", 32'(frame_cnt), 2);
        chk("stall release res_valid", 32'(res_valid), 0);
        tick();
        chk("stall single increment", 32'(frame_cnt), 2);

        // Gapped input: 3 words, 5 idle cycles, 3 words
        send_word(9'd10); send_word(9'd20); send_word(9'd30);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("gap a held", 32'(a), 511);
            chk("gap in_ready", 32'(in_ready), 1);
        end
        send_word(9'd40); send_word(9'd50);
        chk("gap f held", 32'(f), 511);
        send_word(9'd60);
        in_valid = 1'b0;
        chk("gap a", 32'(a), 10);
        chk("gap f", 32'(f), 60);
        tick();
        chk("gap res_out", 32'(res_out), 210);
        chk("gap res_max", 32'(res_max), 60);
        tick();
        chk("gap frame_cnt", 32'(frame_cnt), 3);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("gap single result", 32'(res_valid), 0);
        end

        // Reset asserted mid-frame discards the partial frame
        for (int i = 0; i < 4; i++) send_word(9'd7);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async reset");
        tick();
        tick();
        chk_zero("held reset");
        rst = 1'b0;
        send_word(9'd1); send_word(9'd1); send_word(9'd2);
        send_word(9'd2); send_word(9'd3); send_word(9'd3);
        in_valid = 1'b0;
        wait_valid("post-reset");
        chk("post-reset res_out", 32'(res_out), 12);
        chk("post-reset res_max", 32'(res_max), 3);
        tick();
        chk("post-reset frame_cnt", 32'(frame_cnt), 1);

`ifdef TRI_FRAME_PEAK_EN
        // Peak tracking over results 21, 40, 40, 7
        do_reset();
        run_frame(9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6);
        run_frame(9'd5, 9'd5, 9'd5, 9'd5, 9'd10, 9'd10);
        run_frame(9'd10, 9'd10, 9'd10, 9'd10, 9'd0, 9'd0);
        run_frame(9'd1, 9'd1, 9'd1, 9'd1, 9'd1, 9'd2);
        chk("peak_out", 32'(peak_out), 40);
        chk("peak_idx", 32'(peak_idx), 1);
        chk("peak frame_cnt", 32'(frame_cnt), 4);
`endif

        // frame_cnt wraps modulo 2048
        do_reset();
        for (int n = 0; n < 2047; n++) run_frame('0, '0, '0, '0, '0, '0);
        chk("wrap 2047", 32'(frame_cnt), 2047);
        run_frame('0, '0, '0, '0, '0, '0);
        chk("wrap 2048", 32'(frame_cnt), 0);
        run_frame('0, '0, '0, '0, '0, '0);
        chk("wrap 2049", 32'(frame_cnt), 1);

        // CORE_LAT=3: the result is captured at edge N+4
        res_ready3 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_valid3 = 1'b1;
            in_data3  = 9'(2 * i);
            chk("lat3 in_ready", 32'(in_ready3), 1);
            tick();
        end
        in_valid3 = 1'b0;
        chk("lat3 busy", 32'(busy3), 1);
        chk("lat3 a", 32'(a3), 2);
        chk("lat3 f", 32'(f3), 12);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("lat3 res_valid early", 32'(res_valid3), 0);
        end
        tick();
        chk("lat3 res_valid", 32'(res_valid3), 1);
        chk("lat3 res_out", 32'(res_out3), 42);
        chk("lat3 res_max", 32'(res_max3), 12);
        res_ready3 = 1'b1;
        tick();
        chk("lat3 frame_cnt", 32'(frame_cnt3), 1);
        chk("lat3 in_ready after", 32'(in_ready3), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
